// File: rtl/key_sw_io_responder_if.sv
// CPU load/store bus as seen by the KEY/SW responder.
// The master drives the address and strobes; the responder returns data, hit and irq.
interface key_sw_io_responder_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic             rd_en;
  logic             wr_en;
  logic [DBITS-1:0] wdata;
  logic [DBITS-1:0] rdata;
  logic             hit;
  logic             irq;

  modport master (
    output addr, rd_en, wr_en, wdata,
    input  rdata, hit, irq
  );

  modport slave (
    input  addr, rd_en, wr_en, wdata,
    output rdata, hit, irq
  );
endinterface

// File: rtl/key_sw_io_responder.sv
// Memory-mapped KEY/SW responder: synchronise, debounce, track change/overrun status,
// and serve combinational CPU reads with read/write side effects committed on clk.
module key_sw_io_responder #(
  parameter int               DBITS           = 32,
  parameter int               NKEYS           = 4,
  parameter int               NSW             = 10,
  parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF000_0010,
  parameter logic [DBITS-1:0] ADDR_SW         = 32'hF000_0014,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF000_0110,
  parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF000_0114,
  parameter int               DEBOUNCE_CYCLES = 1000,
  parameter int               CNT_BITS        = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  key_sw_io_responder_if.slave   bus,
  input  logic [NKEYS-1:0]       KEY,
  input  logic [NSW-1:0]         SW
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [NKEYS-1:0]    k_sync1_r, k_sync2_r, k_stable_r, k_upd_s;
  logic [CNT_BITS-1:0] k_cnt_r [NKEYS];
  logic [NSW-1:0]      s_sync1_r, s_sync2_r, s_stable_r, s_upd_s;
  logic [CNT_BITS-1:0] s_cnt_r [NSW];

  logic k_event_s, s_event_s;
  logic k_rd_clr_s, s_rd_clr_s, k_wr_ctrl_s, s_wr_ctrl_s;
  logic k_ready_r, k_ovr_r, k_ie_r, s_ready_r, s_ovr_r, s_ie_r;
  logic k_ready_nxt_s, k_ovr_nxt_s, k_ie_nxt_s;
  logic s_ready_nxt_s, s_ovr_nxt_s, s_ie_nxt_s;
  logic unused_wdata_s;

  function automatic logic [DBITS-1:0] ctrl_word(input logic rdy, input logic ovr, input logic ie);
    logic [DBITS-1:0] w;
    w    = '0;
    w[0] = rdy;
    w[2] = ovr;
    w[8] = ie;
    return w;
  endfunction

  // Two-flop synchronisers; keys are inverted so a pressed key reads as 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_sync1_r <= '0;
      k_sync2_r <= '0;
      s_sync1_r <= '0;
      s_sync2_r <= '0;
    end else begin
      k_sync1_r <= ~KEY;
      k_sync2_r <= k_sync1_r;
      s_sync1_r <= SW;
      s_sync2_r <= s_sync1_r;
    end
  end

  // A bit is accepted on the cycle its counter has already reached the limit.
  always_comb begin
    k_upd_s = '0;
    s_upd_s = '0;
    for (int i = 0; i < NKEYS; i++) begin
      k_upd_s[i] = (k_sync2_r[i] != k_stable_r[i]) && (k_cnt_r[i] == CNT_MAX);
    end
    for (int i = 0; i < NSW; i++) begin
      s_upd_s[i] = (s_sync2_r[i] != s_stable_r[i]) && (s_cnt_r[i] == CNT_MAX);
    end
  end

  assign k_event_s = |k_upd_s;
  assign s_event_s = |s_upd_s;

  // Per-bit debounce counters and accepted (stable) values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_stable_r <= '0;
      s_stable_r <= '0;
      for (int i = 0; i < NKEYS; i++) k_cnt_r[i] <= '0;
      for (int i = 0; i < NSW; i++)   s_cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (k_sync2_r[i] == k_stable_r[i]) begin
          k_cnt_r[i] <= '0;
        end else if (k_upd_s[i]) begin
          k_cnt_r[i]    <= '0;
          k_stable_r[i] <= k_sync2_r[i];
        end else begin
          k_cnt_r[i] <= k_cnt_r[i] + CNT_ONE;
        end
      end
      for (int i = 0; i < NSW; i++) begin
        if (s_sync2_r[i] == s_stable_r[i]) begin
          s_cnt_r[i] <= '0;
        end else if (s_upd_s[i]) begin
          s_cnt_r[i]    <= '0;
          s_stable_r[i] <= s_sync2_r[i];
        end else begin
          s_cnt_r[i] <= s_cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  assign k_rd_clr_s  = bus.rd_en && (bus.addr == ADDR_KEY);
  assign s_rd_clr_s  = bus.rd_en && (bus.addr == ADDR_SW);
  assign k_wr_ctrl_s = bus.wr_en && (bus.addr == ADDR_KCTRL);
  assign s_wr_ctrl_s = bus.wr_en && (bus.addr == ADDR_SCTRL);

  // Status next-state: a change event beats a clearing read and an overrun-clearing write.
  always_comb begin
    k_ready_nxt_s = k_ready_r;
    k_ovr_nxt_s   = k_ovr_r;
    k_ie_nxt_s    = k_ie_r;
    s_ready_nxt_s = s_ready_r;
    s_ovr_nxt_s   = s_ovr_r;
    s_ie_nxt_s    = s_ie_r;

    if (k_event_s)       k_ready_nxt_s = 1'b1;
    else if (k_rd_clr_s) k_ready_nxt_s = 1'b0;
    else                 k_ready_nxt_s = k_ready_r;

    if (k_event_s && k_ready_r && !k_rd_clr_s) k_ovr_nxt_s = 1'b1;
    else if (k_wr_ctrl_s && !bus.wdata[2])     k_ovr_nxt_s = 1'b0;
    else                                       k_ovr_nxt_s = k_ovr_r;

    if (k_wr_ctrl_s) k_ie_nxt_s = bus.wdata[8];
    else             k_ie_nxt_s = k_ie_r;

    if (s_event_s)       s_ready_nxt_s = 1'b1;
    else if (s_rd_clr_s) s_ready_nxt_s = 1'b0;
    else                 s_ready_nxt_s = s_ready_r;

    if (s_event_s && s_ready_r && !s_rd_clr_s) s_ovr_nxt_s = 1'b1;
    else if (s_wr_ctrl_s && !bus.wdata[2])     s_ovr_nxt_s = 1'b0;
    else                                       s_ovr_nxt_s = s_ovr_r;

    if (s_wr_ctrl_s) s_ie_nxt_s = bus.wdata[8];
    else             s_ie_nxt_s = s_ie_r;
  end

  // Status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_ready_r <= 1'b0;
      k_ovr_r   <= 1'b0;
      k_ie_r    <= 1'b0;
      s_ready_r <= 1'b0;
      s_ovr_r   <= 1'b0;
      s_ie_r    <= 1'b0;
    end else begin
      k_ready_r <= k_ready_nxt_s;
      k_ovr_r   <= k_ovr_nxt_s;
      k_ie_r    <= k_ie_nxt_s;
      s_ready_r <= s_ready_nxt_s;
      s_ovr_r   <= s_ovr_nxt_s;
      s_ie_r    <= s_ie_nxt_s;
    end
  end

  // Combinational read mux.
  always_comb begin
    bus.rdata = '0;
    bus.hit   = 1'b0;
    case (bus.addr)
      ADDR_KEY: begin
        bus.rdata = DBITS'(k_stable_r);
        bus.hit   = 1'b1;
      end
      ADDR_SW: begin
        bus.rdata = DBITS'(s_stable_r);
        bus.hit   = 1'b1;
      end
      ADDR_KCTRL: begin
        bus.rdata = ctrl_word(k_ready_r, k_ovr_r, k_ie_r);
        bus.hit   = 1'b1;
      end
      ADDR_SCTRL: begin
        bus.rdata = ctrl_word(s_ready_r, s_ovr_r, s_ie_r);
        bus.hit   = 1'b1;
      end
      default: begin
        bus.rdata = '0;
        bus.hit   = 1'b0;
      end
    endcase
  end

  assign bus.irq = (k_ready_r & k_ie_r) | (s_ready_r & s_ie_r);

  assign unused_wdata_s = ^{bus.wdata[DBITS-1:9], bus.wdata[7:3], bus.wdata[1:0]};

endmodule

// File: tb/tb_key_sw_io_responder.sv
// Scoreboard bench for key_sw_io_responder with an 8-cycle debounce window.
module tb_key_sw_io_responder;
  localparam logic [31:0] A_KEY   = 32'hF000_0010;
  localparam logic [31:0] A_SW    = 32'hF000_0014;
  localparam logic [31:0] A_KCTRL = 32'hF000_0110;
  localparam logic [31:0] A_SCTRL = 32'hF000_0114;
  localparam logic [31:0] A_NONE  = 32'hF000_0018;

  typedef struct packed {
    logic [31:0] rdata;
    logic        hit;
    logic        irq;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] KEY;
  logic [9:0] SW;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  key_sw_io_responder_if #(.DBITS(32)) bus ();

  key_sw_io_responder #(
    .DEBOUNCE_CYCLES (8),
    .CNT_BITS        (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .KEY     (KEY),
    .SW      (SW)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic h,
                    input logic ir, input string nm);
    exp_t e;
    e.rdata = d;
    e.hit   = h;
    e.irq   = ir;
    exp_q.push_back(e);
    name_q.push_back(nm);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    step(1);
    bus.rd_en = 1'b0;
    bus.addr  = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wr_en = 1'b1;
    step(1);
    bus.wr_en = 1'b0;
    bus.wdata = 32'h0;
    bus.addr  = 32'h0;
  endtask

  // Monitor: every read cycle is checked against the oldest queued expectation.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (bus.rd_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_read: addr=%h with empty scoreboard", bus.addr);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          tests++;
          if (bus.rdata !== e.rdata) begin
            fails++;
            $display("FAIL %s rdata: got %h expected %h", nm, bus.rdata, e.rdata);
          end
          tests++;
          if (bus.hit !== e.hit) begin
            fails++;
            $display("FAIL %s hit: got %b expected %b", nm, bus.hit, e.hit);
          end
          tests++;
          if (bus.irq !== e.irq) begin
            fails++;
            $display("FAIL %s irq: got %b expected %b", nm, bus.irq, e.irq);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    KEY       = 4'hF;
    SW        = 10'h000;
    bus.addr  = 32'h0;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.wdata = 32'h0;
    step(2);

    rd(A_KEY,   32'h0, 1'b1, 1'b0, "rst_kdata");
    rd(A_KCTRL, 32'h0, 1'b1, 1'b0, "rst_kctrl");
    rd(A_NONE,  32'h0, 1'b0, 1'b0, "unmapped");
    reset_n = 1'b1;
    step(2);

    // Debounce latency: press at edge 0, visible after edge 10.
    KEY = 4'b1110;
    step(9);
    rd(A_KEY,   32'h0, 1'b1, 1'b0, "deb_early");
    rd(A_KCTRL, 32'h1, 1'b1, 1'b0, "deb_ready");
    rd(A_KEY,   32'h1, 1'b1, 1'b0, "rd_clr_data");
    rd(A_KCTRL, 32'h0, 1'b1, 1'b0, "rd_clr_ctrl");

    // Short glitch on key 1 is rejected.
    KEY = 4'b1100;
    step(5);
    KEY = 4'b1110;
    step(12);
    rd(A_KCTRL, 32'h0, 1'b1, 1'b0, "glitch_ready");
    rd(A_KEY,   32'h1, 1'b1, 1'b0, "glitch_data");

    // Collision: clearing read on the same edge as a new key update.
    KEY = 4'b1111;
    step(12);
    rd(A_KCTRL, 32'h1, 1'b1, 1'b0, "rel_ready");
    KEY = 4'b1110;
    step(9);
    rd(A_KEY,   32'h0, 1'b1, 1'b0, "coll_data");
    rd(A_KCTRL, 32'h1, 1'b1, 1'b0, "coll_ctrl");
    rd(A_KEY,   32'h1, 1'b1, 1'b0, "coll_clr");

    // Switch overrun and its clearing.
    SW = 10'h001;
    step(12);
    SW = 10'h003;
    step(12);
    rd(A_SCTRL, 32'h5, 1'b1, 1'b0, "ovr_set");
    rd(A_SW,    32'h3, 1'b1, 1'b0, "ovr_sdata");
    rd(A_SCTRL, 32'h4, 1'b1, 1'b0, "ovr_sticky");
    wr(A_SCTRL, 32'h0);
    rd(A_SCTRL, 32'h0, 1'b1, 1'b0, "ovr_clear");

    // Overrun-setting event beats an overrun-clearing write on the same edge.
    SW = 10'h007;
    step(12);
    SW = 10'h00F;
    step(9);
    wr(A_SCTRL, 32'h0);
    rd(A_SCTRL, 32'h5, 1'b1, 1'b0, "ovr_same_edge");
    wr(A_SCTRL, 32'h0);
    rd(A_SW,    32'hF, 1'b1, 1'b0, "sdata_f");
    wr(A_SCTRL, 32'h1);
    rd(A_SCTRL, 32'h0, 1'b1, 1'b0, "ready_ro");

    wr(A_KEY, 32'h0000_FFFF);
    rd(A_KEY, 32'h1, 1'b1, 1'b0, "kdata_wr_ign");

    // Interrupt enable and masking.
    wr(A_KCTRL, 32'h100);
    rd(A_KCTRL, 32'h100, 1'b1, 1'b0, "ie_set");
    KEY = 4'b1111;
    step(12);
    rd(A_KCTRL, 32'h101, 1'b1, 1'b1, "irq_on");
    rd(A_KEY,   32'h0,   1'b1, 1'b1, "irq_kdata");
    rd(A_KCTRL, 32'h100, 1'b1, 1'b0, "irq_off");
    wr(A_KCTRL, 32'h0);
    KEY = 4'b1110;
    step(12);
    rd(A_KCTRL, 32'h1, 1'b1, 1'b0, "irq_masked");

    // Reset in the middle of a count, then re-debounce from zero.
    KEY = 4'b1111;
    step(12);
    rd(A_KEY, 32'h0, 1'b1, 1'b0, "pre_rst");
    KEY = 4'b1110;
    step(7);
    reset_n = 1'b0;
    rd(A_KEY,   32'h0, 1'b1, 1'b0, "rst_mid_kdata");
    rd(A_KCTRL, 32'h0, 1'b1, 1'b0, "rst_mid_kctrl");
    rd(A_SW,    32'h0, 1'b1, 1'b0, "rst_mid_sdata");
    reset_n = 1'b1;
    step(9);
    rd(A_KEY, 32'h0, 1'b1, 1'b0, "rerun_early");
    rd(A_KEY, 32'h1, 1'b1, 1'b0, "rerun_data");

    step(2);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
